// File: rtl/ahb_dma_master.sv
// AHB-Lite single-beat DMA initiator driven from a valid/ready command port.
// Optional command alignment rejection is compiled in with AHB_DMA_MASTER_ALIGN_CHK_EN.
//
// state | meaning
// IDLE  | cmd_ready high, bus idle, response strobe may be active
// ADDR  | NONSEQ address phase, held until HREADY
// DATA  | data phase, HTRANS idle, held until HREADY completes the beat
module ahb_dma_master #(
    parameter logic [3:0] HPROT_VAL = 4'b0011,
    parameter int         CNT_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [2:0]       cmd_size,
    input  logic [63:0]      cmd_wdata,
    output logic             rsp_valid,
    output logic [63:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic             HMASTLOCK,
    output logic [63:0]      HWDATA,
    input  logic [63:0]      HRDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state;
    logic [63:0] wdata_q;
    logic        accept;
    logic        reject;

    assign accept = cmd_valid & cmd_ready;

`ifdef AHB_DMA_MASTER_ALIGN_CHK_EN
    function automatic logic cmd_bad(input logic [2:0] size, input logic [2:0] lsb);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = lsb[0];
            3'd2:    bad = |lsb[1:0];
            3'd3:    bad = |lsb;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign reject = cmd_bad(cmd_size, cmd_addr[2:0]);
`else
    assign reject = 1'b0;
`endif

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            HTRANS    <= TRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= '0;
            HWDATA    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (reject) begin
                            // rejected commands never reach the bus but still report and count
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            xfer_cnt  <= xfer_cnt + CNT_W'(1);
                        end else begin
                            state     <= ADDR;
                            cmd_ready <= 1'b0;
                            HTRANS    <= TRANS_NONSEQ;
                            HADDR     <= cmd_addr;
                            HWRITE    <= cmd_write;
                            HSIZE     <= cmd_size;
                            wdata_q   <= cmd_wdata;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        state  <= DATA;
                        HTRANS <= TRANS_IDLE;
                        if (HWRITE) begin
                            HWDATA <= wdata_q;
                        end
                    end
                end
                DATA: begin
                    // an error's first cycle has HREADY low, so it simply waits here
                    if (HREADY) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_rdata <= HWRITE ? 64'h0 : HRDATA;
                        xfer_cnt  <= xfer_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    HTRANS    <= TRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Self-checking bench for ahb_dma_master: vector table plus scoreboard of responses.
// Build with AHB_DMA_MASTER_ALIGN_CHK_EN defined to exercise command rejection.
module tb_ahb_dma_master;

    localparam int CNT_W = 3;
    localparam int MASK  = (1 << CNT_W) - 1;

    logic             HCLK;
    logic             HRESETn;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [2:0]       cmd_size;
    logic [63:0]      cmd_wdata;
    logic             rsp_valid;
    logic [63:0]      rsp_rdata;
    logic             rsp_err;
    logic [CNT_W-1:0] xfer_cnt;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic             HWRITE;
    logic [2:0]       HSIZE;
    logic [2:0]       HBURST;
    logic [3:0]       HPROT;
    logic             HMASTLOCK;
    logic [63:0]      HWDATA;
    logic [63:0]      HRDATA;
    logic             HREADY;
    logic             HRESP;

    ahb_dma_master #(.HPROT_VAL(4'b0011), .CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .xfer_cnt(xfer_cnt),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          wa;
        int          wd;
        logic        err;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          acc_cyc;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   exp_cnt = 0;
    exp_t sb_q[$];
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // response monitor: pops the scoreboard on every strobe
    always @(negedge HCLK) begin
        exp_t e;
        cyc++;
        if (rsp_valid) begin
            chk("rsp_outstanding", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                exp_cnt++;
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                chk("xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt & MASK));
            end
        end
    end

    // called at a negedge; returns at the negedge of the response cycle
    task automatic run_xfer(input vec_t v);
        int la;
        int ld;
        int j;
        la = 1 + v.wa;
        ld = la + 1 + v.wd;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_size  = v.size;
        cmd_wdata = v.wdata;
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        @(posedge HCLK);
        sb_q.push_back('{v.err, v.wr ? 64'h0 : v.rdata, ld + 1, cyc});
        for (int k = 1; k <= ld + 1; k++) begin
            @(negedge HCLK);
            if (k <= ld) begin
                cmd_valid = 1'b1;
                cmd_addr  = $urandom;
                cmd_write = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'b0;
            end
            chk("busy_ready", 64'(cmd_ready), (k > ld) ? 64'd1 : 64'd0);
            if (k <= la) begin
                chk("addr_htrans", 64'(HTRANS), 64'd2);
                chk("addr_haddr", 64'(HADDR), 64'(v.addr));
                chk("addr_hwrite", 64'(HWRITE), 64'(v.wr));
                chk("addr_hsize", 64'(HSIZE), 64'(v.size));
                chk("addr_no_rsp", 64'(rsp_valid), 64'd0);
                HREADY = (k == la);
                HRESP  = 1'b0;
                HRDATA = {$urandom, $urandom};
            end else if (k <= ld) begin
                j = k - la;
                chk("data_htrans", 64'(HTRANS), 64'd0);
                if (v.wr) chk("data_hwdata", HWDATA, v.wdata);
                chk("data_no_rsp", 64'(rsp_valid), 64'd0);
                HREADY = (j == 1 + v.wd);
                HRESP  = v.err && (j >= v.wd);
                HRDATA = HREADY ? v.rdata : {$urandom, $urandom};
            end else begin
                chk("rsp_strobe", 64'(rsp_valid), 64'd1);
                chk("rsp_htrans", 64'(HTRANS), 64'd0);
                HREADY = 1'($urandom_range(0, 1));
                HRESP  = 1'b0;
            end
        end
    endtask

`ifdef AHB_DMA_MASTER_ALIGN_CHK_EN
    task automatic run_reject(input logic [31:0] a, input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = 64'hFEEDFACE00000000;
        HREADY    = 1'b1;
        chk("rej_ready", 64'(cmd_ready), 64'd1);
        @(posedge HCLK);
        sb_q.push_back('{1'b1, 64'h0, 1, cyc});
        @(negedge HCLK);
        cmd_valid = 1'b0;
        chk("rej_htrans", 64'(HTRANS), 64'd0);
        chk("rej_rsp", 64'(rsp_valid), 64'd1);
        chk("rej_err", 64'(rsp_err), 64'd1);
        chk("rej_ready_after", 64'(cmd_ready), 64'd1);
        @(negedge HCLK);
        chk("rej_htrans2", 64'(HTRANS), 64'd0);
        chk("rej_one_pulse", 64'(rsp_valid), 64'd0);
    endtask
`endif

    initial begin
        vec_t v;
        int   acc_t[4];
        int   n;
        logic acc;

        tbl[0] = '{1'b1, 32'hF0040000, 3'd3, 64'h1122334455667788, 64'h0, 0, 0, 1'b0};
        tbl[1] = '{1'b0, 32'h00001000, 3'd3, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 2, 1'b0};
        tbl[2] = '{1'b1, 32'h00002008, 3'd2, 64'h00000000AABBCCDD, 64'h0, 0, 1, 1'b1};
        tbl[3] = '{1'b0, 32'h00002004, 3'd2, 64'h0, 64'h0000000012345678, 1, 0, 1'b0};
        tbl[4] = '{1'b1, 32'h00003001, 3'd0, 64'h0000000000005A00, 64'h0, 2, 1, 1'b0};
        tbl[5] = '{1'b0, 32'h00004002, 3'd1, 64'h0, 64'h00000000BEEF0000, 1, 1, 1'b0};

        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
        HRDATA = '0; HREADY = 1'b0; HRESP = 1'b0;
        repeat (2) @(negedge HCLK);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_htrans", 64'(HTRANS), 64'd0);
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwdata", HWDATA, 64'd0);
        chk("rst_rsp", 64'(rsp_valid), 64'd0);
        chk("rst_cnt", 64'(xfer_cnt), 64'd0);
        chk("const_hprot", 64'(HPROT), 64'd3);
        chk("const_hburst", 64'(HBURST), 64'd0);
        chk("const_lock", 64'(HMASTLOCK), 64'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

        // back-to-back with cmd_valid held high: alternate writes and reads
        for (int i = 0; i < 4; i++) acc_t[i] = -1;
        n = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 64'h0BADF00D600DCAFE;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000; cmd_size = 3'd3;
        cmd_wdata = 64'h100;
        for (int t = 0; t < 14; t++) begin
            acc = cmd_valid && cmd_ready;
            @(posedge HCLK);
            if (acc) begin
                sb_q.push_back('{1'b0, cmd_write ? 64'h0 : HRDATA, 3, cyc});
                if (n < 4) acc_t[n] = t;
                n++;
            end
            @(negedge HCLK);
            if (acc) begin
                if (n >= 4) cmd_valid = 1'b0;
                cmd_write = ~cmd_write;
                cmd_addr  = cmd_addr + 32'h8;
                cmd_wdata = cmd_wdata + 64'h1;
            end
        end
        chk("b2b_count", 64'(n), 64'd4);
        for (int i = 0; i < 4; i++) chk("b2b_accept_cycle", 64'(acc_t[i]), 64'(3 * i));
        chk("b2b_cnt", 64'(xfer_cnt), 64'(exp_cnt & MASK));

        // reset while a write sits in a wait-stated data phase
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000; cmd_size = 3'd3;
        cmd_wdata = 64'hA5A5A5A55A5A5A5A; HREADY = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK); cmd_valid = 1'b0; HREADY = 1'b1;
        @(negedge HCLK); HREADY = 1'b0;
        chk("mid_in_data", HWDATA, 64'hA5A5A5A55A5A5A5A);
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        chk("mid_ready", 64'(cmd_ready), 64'd1);
        chk("mid_htrans", 64'(HTRANS), 64'd0);
        chk("mid_haddr", 64'(HADDR), 64'd0);
        chk("mid_hwrite", 64'(HWRITE), 64'd0);
        chk("mid_hsize", 64'(HSIZE), 64'd0);
        chk("mid_hwdata", HWDATA, 64'd0);
        chk("mid_rsp", 64'(rsp_valid), 64'd0);
        chk("mid_rdata", rsp_rdata, 64'd0);
        chk("mid_err", 64'(rsp_err), 64'd0);
        chk("mid_cnt", 64'(xfer_cnt), 64'd0);
        HREADY = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        exp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("post_rst_ready", 64'(cmd_ready), 64'd1);
            chk("post_rst_htrans", 64'(HTRANS), 64'd0);
        end

        v = '{1'b0, 32'h00009008, 3'd3, 64'h0, 64'h0123456789ABCDEF, 0, 0, 1'b0};
        run_xfer(v);

`ifdef AHB_DMA_MASTER_ALIGN_CHK_EN
        run_reject(32'h0000A002, 3'd2);
        run_reject(32'h0000B000, 3'd4);
        v = '{1'b1, 32'h0000A004, 3'd2, 64'h0000000011110000, 64'h0, 0, 1, 1'b0};
        run_xfer(v);
`else
        v = '{1'b0, 32'h00007003, 3'd5, 64'h0, 64'h7777000077770000, 0, 1, 1'b0};
        run_xfer(v);
`endif

        repeat (4) @(negedge HCLK);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_dma_master.md
# ahb_dma_master

AHB-Lite master that drives the core's DMA slave port (`dma_h*`) from a simple valid/ready command interface. It issues one single-beat transfer (read or write) at a time, then returns read data and error status on a one-cycle response strobe. Benches use it to preload or inspect DCCM/ICCM through DMA, and SoC glue uses it as the initiator side of the AHB link that the `ahb_sif` memory model terminates.

## Interface
Parameters:
- `HPROT_VAL`, default `4'b0011`: constant driven on `HPROT` (data, privileged).
- `CNT_W`, default `16`: width of the completed-transfer counter.

Ports:
- `HCLK`  in  1  clock.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at `HCLK` posedge.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  32  byte address.
- `cmd_size`  in  3  `HSIZE` encoding: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `cmd_wdata`  in  64  write data, already lane-placed by the caller.
- `rsp_valid`  out  1  one-cycle completion strobe. There is no backpressure on it.
- `rsp_rdata`  out  64  read data. Valid with `rsp_valid` on reads; 0 on writes.
- `rsp_err`  out  1  transfer ended with `HRESP=1`, or was rejected as misaligned.
- `xfer_cnt`  out  `CNT_W`  count of completed responses. Wraps modulo 2^`CNT_W`.
- `HADDR`  out  32, `HTRANS`  out  2, `HWRITE`  out  1, `HSIZE`  out  3, `HBURST`  out  3, `HPROT`  out  4, `HMASTLOCK`  out  1, `HWDATA`  out  64: AHB-Lite master outputs.
- `HRDATA`  in  64, `HREADY`  in  1, `HRESP`  in  1: AHB-Lite slave responses.

## Operation
- States: `IDLE`, `ADDR`, `DATA`.
- **IDLE**
  - `cmd_ready=1` and `HTRANS=2'b00`.
  - On accept, the block latches `cmd_*` and goes to `ADDR`.
- **ADDR**
  - Drives `HTRANS=2'b10` (NONSEQ), `HADDR`, `HWRITE` and `HSIZE` from the latched command.
  - Holds them stable while `HREADY=0`.
  - On `HREADY=1` at a posedge it goes to `DATA`.
- **DATA**
  - Drives `HTRANS=2'b00`. On writes it also drives `HWDATA` with the latched wdata, held stable until completion.
  - `HREADY=0` means wait.
  - `HREADY=1` completes the transfer. The block captures `HRDATA` (reads only) and `HRESP`, then returns to `IDLE`.
- **Error response.** `HRESP=1` with `HREADY=0` is the first error cycle; the block keeps waiting. The second cycle (`HREADY=1`, `HRESP=1`) completes the transfer with `rsp_err=1`. `HTRANS` is already IDLE, so there is no cancellation logic.
- **Response.** `rsp_valid` pulses for exactly one cycle after each completion and `xfer_cnt` increments. Error responses count too.
- **Constant outputs:** `HBURST=3'b000`, `HMASTLOCK=0`, `HPROT=HPROT_VAL`.
- `cmd_size` values 4–7 are passed to `HSIZE` unmodified when the alignment check is compiled out.

## Timing
- **Reset values:** `cmd_ready=1` (state `IDLE`), `HTRANS=0`, `HADDR=0`, `HWRITE=0`, `HSIZE=0`, `HWDATA=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `xfer_cnt=0`.
- **Latency with zero wait states:**
  - accept at edge E0;
  - address phase in cycle E0–E1;
  - data phase in cycle E1–E2;
  - `rsp_valid` high in cycle E2–E3.
  - Each wait state (`HREADY=0`) adds one cycle.
- **Back-to-back throughput.** `cmd_ready=1` during the `rsp_valid` cycle, so a new command can be accepted at E3. Sustained rate is one transfer per 3 cycles.
- **`cmd_ready` is 0** in `ADDR` and `DATA`. While busy, `cmd_*` changes are ignored.
- **`HREADY` sampling.** `HREADY` is sampled in `IDLE` but ignored there.
- **Reset mid-transfer.** `HRESETn` low in any state immediately forces all registered outputs to their reset values. No response is generated for the aborted command.
- **Counter wrap.** The `xfer_cnt` rollover from all-ones to 0 is an ordinary increment.

## Configuration
- **`AHB_DMA_MASTER_ALIGN_CHK_EN` defined:**
  - On accept, the block checks `cmd_addr` against `cmd_size`. The command is rejected if `cmd_size>3`, or if the address is misaligned (`cmd_addr & ((1<<cmd_size)-1) != 0`).
  - A rejected command issues no bus transfer (`HTRANS` stays 0). The block stays in `IDLE` and pulses `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` in the next cycle.
  - `xfer_cnt` increments for the rejection.
- **Undefined:** no check is made, and every accepted command goes on the bus as issued.

## Test plan
- **Zero-wait write:** write at 0xF0040000, size 3, wdata 0x1122334455667788. Required: `HTRANS=2` for 1 cycle, `HWDATA` matches in the next cycle, `rsp_valid` 3 cycles after accept, `rsp_err=0`, `xfer_cnt=1`.
- **Read with 2 wait states:** slave returns `HRDATA=0xDEADBEEFCAFEF00D`. Required: `rsp_valid` 5 cycles after accept, `rsp_rdata` equal to that value.
- **Two-cycle error response:** `HRESP=1`/`HREADY=0`, then `HRESP=1`/`HREADY=1`. Required: `rsp_err=1`, `HTRANS=0` throughout the data phase, then a following command completes normally.
- **Back-to-back:** 4 commands with `cmd_valid` held high. Required: accepts at cycles 0, 3, 6, 9; `xfer_cnt=4`.
- **Reset during wait-stated data phase:** required: all outputs at reset values the same cycle, no `rsp_valid`, `cmd_ready=1` after release.
- **Misaligned command** (`AHB_DMA_MASTER_ALIGN_CHK_EN`): addr 0x…02, size 2. Required: no NONSEQ, `rsp_err=1` one cycle after accept.
